// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control FSM.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC_R = 4'd3,
    S_WB_R   = 4'd4,
    S_EXEC_I = 4'd5,
    S_WB_I   = 4'd6,
    S_ADDR   = 4'd7,
    S_MEM_RD = 4'd8,
    S_WB_MEM = 4'd9,
    S_MEM_WR = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12,
    S_JR     = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE    = 6'h00;
  localparam logic [5:0] OP_J        = 6'h02;
  localparam logic [5:0] OP_JAL      = 6'h03;
  localparam logic [5:0] OP_BEQ      = 6'h04;
  localparam logic [5:0] OP_BNE      = 6'h05;
  localparam logic [5:0] OP_ITYPE_LO = 6'h08;
  localparam logic [5:0] OP_LUI      = 6'h0f;
  localparam logic [5:0] OP_LW       = 6'h23;
  localparam logic [5:0] OP_SB       = 6'h28;
  localparam logic [5:0] OP_SH       = 6'h29;
  localparam logic [5:0] OP_SW       = 6'h2b;
  localparam logic [5:0] FN_JR       = 6'h08;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_RS     = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       iord;
    logic       reg_read;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       branch;
    logic       branch_ne;
    logic [1:0] pc_src;
  } ctrl_t;

endpackage

// File: rtl/ctrl_mem_wait_timer.sv
// Counts cycles spent waiting on mem_ready and flags the abort cycle.
module ctrl_mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic clear,
  input  logic mem_ready,
  output logic expire_c
);

  localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (active && !mem_ready) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Abort on the MEM_TIMEOUT-th consecutive not-ready cycle; a ready that cycle wins.
  assign expire_c = active && !mem_ready && (cnt_q == CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback.
module multicycle_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned OPC_W       = 6,
  parameter int unsigned FUNCT_W     = 6,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               mem_ready,
  input  logic [OPC_W-1:0]   opcode,
  input  logic [FUNCT_W-1:0] funct,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               IorD,
  output logic               RegRead,
  output logic               RegWrite,
  output logic               RegDst,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemToReg,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic               Branch,
  output logic               BranchNe,
  output logic [1:0]         PCSrc,
  output logic [3:0]         state_o,
  output logic               instr_done,
  output logic               illegal,
  output logic               mem_timeout,
  output logic [CNT_W-1:0]   retired
);

  state_e             state_q, state_d;
  logic [OPC_W-1:0]   opc_q, opc_d;
  logic [FUNCT_W-1:0] fn_q, fn_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               instr_done_q, instr_done_d;
  logic               illegal_q, illegal_d;
  logic               mem_timeout_q, mem_timeout_d;

  ctrl_t              ctrl;
  logic               retire_c;
  logic               expire_c;
  logic               wait_active_c;
  logic [OPC_W-1:0]   op;
  logic [FUNCT_W-1:0] fn;

  // IR contents are live in DECODE; later states use the copy latched there.
  assign op = (state_q == S_DECODE) ? opcode : opc_q;
  assign fn = (state_q == S_DECODE) ? funct  : fn_q;

  assign wait_active_c = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);

  ctrl_mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .active   (wait_active_c),
    .clear    (state_d != state_q),
    .mem_ready(mem_ready),
    .expire_c (expire_c)
  );

  always_comb begin
    state_d       = state_q;
    opc_d         = opc_q;
    fn_d          = fn_q;
    ctrl          = '0;
    retire_c      = 1'b0;
    illegal_d     = 1'b0;
    mem_timeout_d = expire_c;

    unique case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        if (mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          state_d       = S_DECODE;
        end else if (expire_c) begin
          state_d = S_IDLE;
        end
      end
      S_DECODE: begin
        ctrl.reg_read  = (op != OPC_W'(OP_LUI));
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALUOP_ADD;
        opc_d          = opcode;
        fn_d           = funct;
        if (op == OPC_W'(OP_RTYPE)) begin
          state_d = (fn == FUNCT_W'(FN_JR)) ? S_JR : S_EXEC_R;
        end else if (op == OPC_W'(OP_LW) || op == OPC_W'(OP_SB) ||
                     op == OPC_W'(OP_SH) || op == OPC_W'(OP_SW)) begin
          state_d = S_ADDR;
        end else if (op == OPC_W'(OP_BEQ) || op == OPC_W'(OP_BNE)) begin
          state_d = S_BRANCH;
        end else if (op == OPC_W'(OP_J) || op == OPC_W'(OP_JAL)) begin
          state_d = S_JUMP;
        end else if (op >= OPC_W'(OP_ITYPE_LO) && op <= OPC_W'(OP_LUI)) begin
          state_d = S_EXEC_I;
        end else begin
          illegal_d = 1'b1;
          state_d   = run ? S_FETCH : S_IDLE;
        end
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = ALUOP_FUNCT;
        state_d        = S_WB_R;
      end
      S_WB_R: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        retire_c       = 1'b1;
      end
      S_EXEC_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ITYPE;
        state_d        = S_WB_I;
      end
      S_WB_I: begin
        ctrl.reg_write = 1'b1;
        retire_c       = 1'b1;
      end
      S_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        state_d        = (op == OPC_W'(OP_LW)) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
        if (mem_ready)     state_d = S_WB_MEM;
        else if (expire_c) state_d = S_IDLE;
      end
      S_WB_MEM: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        retire_c        = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        if (mem_ready)     retire_c = 1'b1;
        else if (expire_c) state_d  = S_IDLE;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.pc_src    = PCSRC_ALUOUT;
        ctrl.branch    = (op == OPC_W'(OP_BEQ));
        ctrl.branch_ne = (op == OPC_W'(OP_BNE));
        retire_c       = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_src    = PCSRC_JUMP;
        ctrl.reg_write = (op == OPC_W'(OP_JAL));
        retire_c       = 1'b1;
      end
      S_JR: begin
        ctrl.reg_read = 1'b1;
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PCSRC_RS;
        retire_c      = 1'b1;
      end
      default: begin
        ctrl.pc_src = PCSRC_ALU;
        state_d     = S_IDLE;
      end
    endcase

    if (retire_c) state_d = run ? S_FETCH : S_IDLE;

    instr_done_d = retire_c;
    retired_d    = retired_q + CNT_W'(retire_c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      opc_q         <= '0;
      fn_q          <= '0;
      retired_q     <= '0;
      instr_done_q  <= 1'b0;
      illegal_q     <= 1'b0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      opc_q         <= opc_d;
      fn_q          <= fn_d;
      retired_q     <= retired_d;
      instr_done_q  <= instr_done_d;
      illegal_q     <= illegal_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign PCWrite     = ctrl.pc_write;
  assign IRWrite     = ctrl.ir_write;
  assign IorD        = ctrl.iord;
  assign RegRead     = ctrl.reg_read;
  assign RegWrite    = ctrl.reg_write;
  assign RegDst      = ctrl.reg_dst;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign MemToReg    = ctrl.mem_to_reg;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ALUOp       = ctrl.alu_op;
  assign Branch      = ctrl.branch;
  assign BranchNe    = ctrl.branch_ne;
  assign PCSrc       = ctrl.pc_src;
  assign state_o     = state_q;
  assign instr_done  = instr_done_q;
  assign illegal     = illegal_q;
  assign mem_timeout = mem_timeout_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed self-checking bench for multicycle_control_fsm (4-bit retire counter).
module tb_multicycle_control_fsm;

  localparam int unsigned CNT_W = 4;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_EXEC_R = 4'd3;
  localparam logic [3:0] S_WB_R   = 4'd4;
  localparam logic [3:0] S_EXEC_I = 4'd5;
  localparam logic [3:0] S_WB_I   = 4'd6;
  localparam logic [3:0] S_ADDR   = 4'd7;
  localparam logic [3:0] S_MEM_RD = 4'd8;
  localparam logic [3:0] S_WB_MEM = 4'd9;
  localparam logic [3:0] S_MEM_WR = 4'd10;
  localparam logic [3:0] S_BRANCH = 4'd11;
  localparam logic [3:0] S_JUMP   = 4'd12;
  localparam logic [3:0] S_JR     = 4'd13;

  // Packs the expected control word in the same order as the ctrl probe below.
  function automatic logic [17:0] cv(input bit pw, iw, iod, rr, rw, rd, mr, mw, mt, sa,
                                     input bit [1:0] sb, op, input bit b, bn, input bit [1:0] ps);
    return {pw, iw, iod, rr, rw, rd, mr, mw, mt, sa, sb, op, b, bn, ps};
  endfunction

  localparam logic [17:0] C_NONE       = 18'd0;
  localparam logic [17:0] C_FETCH_RDY  = cv(1,1,0,0,0,0,1,0,0,0,2'b01,2'b00,0,0,2'b00);
  localparam logic [17:0] C_FETCH_WAIT = cv(0,0,0,0,0,0,1,0,0,0,2'b01,2'b00,0,0,2'b00);
  localparam logic [17:0] C_DECODE     = cv(0,0,0,1,0,0,0,0,0,0,2'b11,2'b00,0,0,2'b00);
  localparam logic [17:0] C_DECODE_LUI = cv(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,0,0,2'b00);
  localparam logic [17:0] C_EXEC_R     = cv(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,0,0,2'b00);
  localparam logic [17:0] C_WB_R       = cv(0,0,0,0,1,1,0,0,0,0,2'b00,2'b00,0,0,2'b00);
  localparam logic [17:0] C_EXEC_I     = cv(0,0,0,0,0,0,0,0,0,1,2'b10,2'b11,0,0,2'b00);
  localparam logic [17:0] C_WB_I       = cv(0,0,0,0,1,0,0,0,0,0,2'b00,2'b00,0,0,2'b00);
  localparam logic [17:0] C_ADDR       = cv(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,0,0,2'b00);
  localparam logic [17:0] C_MEM_RD     = cv(0,0,1,0,0,0,1,0,0,0,2'b00,2'b00,0,0,2'b00);
  localparam logic [17:0] C_WB_MEM     = cv(0,0,0,0,1,0,0,0,1,0,2'b00,2'b00,0,0,2'b00);
  localparam logic [17:0] C_MEM_WR     = cv(0,0,1,0,0,0,0,1,0,0,2'b00,2'b00,0,0,2'b00);
  localparam logic [17:0] C_BEQ        = cv(0,0,0,0,0,0,0,0,0,1,2'b00,2'b01,1,0,2'b01);
  localparam logic [17:0] C_BNE        = cv(0,0,0,0,0,0,0,0,0,1,2'b00,2'b01,0,1,2'b01);
  localparam logic [17:0] C_J          = cv(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,0,0,2'b10);
  localparam logic [17:0] C_JAL        = cv(1,0,0,0,1,0,0,0,0,0,2'b00,2'b00,0,0,2'b10);
  localparam logic [17:0] C_JR         = cv(1,0,0,1,0,0,0,0,0,0,2'b00,2'b00,0,0,2'b11);

  logic             clk = 1'b0;
  logic             rst, run, mem_ready;
  logic [5:0]       opcode, funct;
  logic             PCWrite, IRWrite, IorD, RegRead, RegWrite, RegDst;
  logic             MemRead, MemWrite, MemToReg, ALUSrcA, Branch, BranchNe;
  logic [1:0]       ALUSrcB, ALUOp, PCSrc;
  logic [3:0]       state_o;
  logic             instr_done, illegal, mem_timeout;
  logic [CNT_W-1:0] retired;
  logic [17:0]      ctrl;

  int               checks = 0;
  int               failures = 0;
  logic [CNT_W-1:0] exp_ret = '0;

  multicycle_control_fsm #(
    .OPC_W(6), .FUNCT_W(6), .CNT_W(CNT_W), .MEM_TIMEOUT(15)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .mem_ready(mem_ready),
    .opcode(opcode), .funct(funct),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD), .RegRead(RegRead),
    .RegWrite(RegWrite), .RegDst(RegDst), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemToReg(MemToReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .Branch(Branch), .BranchNe(BranchNe), .PCSrc(PCSrc), .state_o(state_o),
    .instr_done(instr_done), .illegal(illegal), .mem_timeout(mem_timeout),
    .retired(retired)
  );

  assign ctrl = {PCWrite, IRWrite, IorD, RegRead, RegWrite, RegDst, MemRead, MemWrite,
                 MemToReg, ALUSrcA, ALUSrcB, ALUOp, Branch, BranchNe, PCSrc};

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; run = 1'b0; mem_ready = 1'b0; opcode = '0; funct = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (state_o !== S_IDLE || ctrl !== C_NONE || retired !== 4'd0 || {instr_done, illegal, mem_timeout} !== 3'b000) begin failures++; $display("FAIL reset_state state=%0d ctrl=%b ret=%0d pulses=%b required 0", state_o, ctrl, retired, {instr_done, illegal, mem_timeout}); end
    rst = 1'b0;
    tick();
    checks++; if (state_o !== S_IDLE || ctrl !== C_NONE) begin failures++; $display("FAIL idle_hold state=%0d ctrl=%b required %0d %b", state_o, ctrl, S_IDLE, C_NONE); end
  endtask

  task automatic test_rtype;
    opcode = 6'h00; funct = 6'h20; mem_ready = 1'b1; run = 1'b1;
    tick();
    checks++; if (state_o !== S_FETCH || ctrl !== C_FETCH_RDY) begin failures++; $display("FAIL rtype_fetch state=%0d ctrl=%b required %0d %b", state_o, ctrl, S_FETCH, C_FETCH_RDY); end
    run = 1'b0;
    tick();
    checks++; if (state_o !== S_DECODE || ctrl !== C_DECODE) begin failures++; $display("FAIL rtype_decode state=%0d ctrl=%b required %0d %b", state_o, ctrl, S_DECODE, C_DECODE); end
    tick();
    checks++; if (state_o !== S_EXEC_R || ctrl !== C_EXEC_R) begin failures++; $display("FAIL rtype_exec state=%0d ctrl=%b required %0d %b", state_o, ctrl, S_EXEC_R, C_EXEC_R); end
    tick();
    checks++; if (state_o !== S_WB_R || ctrl !== C_WB_R || instr_done !== 1'b0) begin failures++; $display("FAIL rtype_wb state=%0d ctrl=%b done=%b required %0d %b 0", state_o, ctrl, instr_done, S_WB_R, C_WB_R); end
    tick(); exp_ret++;
    checks++; if (state_o !== S_IDLE || instr_done !== 1'b1 || retired !== exp_ret) begin failures++; $display("FAIL rtype_retire state=%0d done=%b ret=%0d required 0 1 %0d", state_o, instr_done, retired, exp_ret); end
    tick();
    checks++; if (instr_done !== 1'b0) begin failures++; $display("FAIL rtype_done_pulse done=%b required 0", instr_done); end
  endtask

  task automatic test_lw_wait;
    opcode = 6'h23; funct = 6'h00; mem_ready = 1'b1; run = 1'b1;
    tick(); run = 1'b0;
    tick();
    tick();
    checks++; if (state_o !== S_ADDR || ctrl !== C_ADDR) begin failures++; $display("FAIL lw_addr state=%0d ctrl=%b required %0d %b", state_o, ctrl, S_ADDR, C_ADDR); end
    mem_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 4) mem_ready = 1'b1;
      checks++; if (state_o !== S_MEM_RD || ctrl !== C_MEM_RD) begin failures++; $display("FAIL lw_mem_rd cycle=%0d state=%0d ctrl=%b required %0d %b", i, state_o, ctrl, S_MEM_RD, C_MEM_RD); end
    end
    tick();
    checks++; if (state_o !== S_WB_MEM || ctrl !== C_WB_MEM || instr_done !== 1'b0) begin failures++; $display("FAIL lw_wb state=%0d ctrl=%b done=%b required %0d %b 0", state_o, ctrl, instr_done, S_WB_MEM, C_WB_MEM); end
    tick(); exp_ret++;
    checks++; if (state_o !== S_IDLE || instr_done !== 1'b1 || retired !== exp_ret) begin failures++; $display("FAIL lw_retire state=%0d done=%b ret=%0d required 0 1 %0d", state_o, instr_done, retired, exp_ret); end
    tick();
    checks++; if (instr_done !== 1'b0) begin failures++; $display("FAIL lw_done_once done=%b required 0", instr_done); end
  endtask

  task automatic test_sw_timeout;
    int bad;
    bad = 0;
    opcode = 6'h2b; funct = 6'h00; mem_ready = 1'b1; run = 1'b1;
    tick(); run = 1'b0;
    tick();
    tick();
    mem_ready = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (state_o !== S_MEM_WR || ctrl !== C_MEM_WR || mem_timeout !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL sw_wait_hold bad_cycles=%0d required 0", bad); end
    tick();
    checks++; if (state_o !== S_IDLE || mem_timeout !== 1'b1 || instr_done !== 1'b0 || retired !== exp_ret || ctrl !== C_NONE) begin failures++; $display("FAIL sw_timeout state=%0d tmo=%b done=%b ret=%0d ctrl=%b required 0 1 0 %0d 0", state_o, mem_timeout, instr_done, retired, ctrl, exp_ret); end
    tick();
    checks++; if (mem_timeout !== 1'b0) begin failures++; $display("FAIL sw_timeout_pulse tmo=%b required 0", mem_timeout); end
  endtask

  task automatic test_mem_boundary;
    opcode = 6'h2b; funct = 6'h00; mem_ready = 1'b0; run = 1'b1;
    tick();
    checks++; if (state_o !== S_FETCH || ctrl !== C_FETCH_WAIT) begin failures++; $display("FAIL fetch_wait state=%0d ctrl=%b required %0d %b", state_o, ctrl, S_FETCH, C_FETCH_WAIT); end
    mem_ready = 1'b1; run = 1'b0;
    #1;
    checks++; if (ctrl !== C_FETCH_RDY) begin failures++; $display("FAIL fetch_ready ctrl=%b required %b", ctrl, C_FETCH_RDY); end
    tick();
    tick();
    mem_ready = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (i == 15) mem_ready = 1'b1;
    end
    checks++; if (state_o !== S_MEM_WR || ctrl !== C_MEM_WR) begin failures++; $display("FAIL bound_last_wait state=%0d ctrl=%b required %0d %b", state_o, ctrl, S_MEM_WR, C_MEM_WR); end
    tick(); exp_ret++;
    checks++; if (state_o !== S_IDLE || instr_done !== 1'b1 || mem_timeout !== 1'b0 || retired !== exp_ret) begin failures++; $display("FAIL bound_complete state=%0d done=%b tmo=%b ret=%0d required 0 1 0 %0d", state_o, instr_done, mem_timeout, retired, exp_ret); end
  endtask

  task automatic test_branch_jump;
    logic [5:0]  op, fn;
    logic [3:0]  es;
    logic [17:0] ec;
    for (int k = 0; k < 5; k++) begin
      case (k)
        0:       begin op = 6'h04; fn = 6'h00; es = S_BRANCH; ec = C_BEQ; end
        1:       begin op = 6'h05; fn = 6'h00; es = S_BRANCH; ec = C_BNE; end
        2:       begin op = 6'h02; fn = 6'h00; es = S_JUMP;   ec = C_J;   end
        3:       begin op = 6'h03; fn = 6'h00; es = S_JUMP;   ec = C_JAL; end
        default: begin op = 6'h00; fn = 6'h08; es = S_JR;     ec = C_JR;  end
      endcase
      opcode = op; funct = fn; mem_ready = 1'b1; run = 1'b1;
      tick(); run = 1'b0;
      tick();
      checks++; if (state_o !== S_DECODE || ctrl !== C_DECODE) begin failures++; $display("FAIL bj_decode op=%h state=%0d ctrl=%b required %0d %b", op, state_o, ctrl, S_DECODE, C_DECODE); end
      tick();
      checks++; if (state_o !== es || ctrl !== ec) begin failures++; $display("FAIL bj_exec op=%h state=%0d ctrl=%b required %0d %b", op, state_o, ctrl, es, ec); end
      tick(); exp_ret++;
      checks++; if (state_o !== S_IDLE || instr_done !== 1'b1 || retired !== exp_ret) begin failures++; $display("FAIL bj_retire op=%h state=%0d done=%b ret=%0d required 0 1 %0d", op, state_o, instr_done, retired, exp_ret); end
    end
  endtask

  task automatic test_itype;
    logic [5:0]  op;
    logic [17:0] dc;
    for (int k = 0; k < 2; k++) begin
      op = (k == 0) ? 6'h08 : 6'h0f;
      dc = (k == 0) ? C_DECODE : C_DECODE_LUI;
      opcode = op; funct = 6'h00; mem_ready = 1'b1; run = 1'b1;
      tick(); run = 1'b0;
      tick();
      checks++; if (state_o !== S_DECODE || ctrl !== dc) begin failures++; $display("FAIL itype_decode op=%h state=%0d ctrl=%b required %0d %b", op, state_o, ctrl, S_DECODE, dc); end
      tick();
      checks++; if (state_o !== S_EXEC_I || ctrl !== C_EXEC_I) begin failures++; $display("FAIL itype_exec op=%h state=%0d ctrl=%b required %0d %b", op, state_o, ctrl, S_EXEC_I, C_EXEC_I); end
      tick();
      checks++; if (state_o !== S_WB_I || ctrl !== C_WB_I) begin failures++; $display("FAIL itype_wb op=%h state=%0d ctrl=%b required %0d %b", op, state_o, ctrl, S_WB_I, C_WB_I); end
      tick(); exp_ret++;
      checks++; if (state_o !== S_IDLE || instr_done !== 1'b1 || retired !== exp_ret) begin failures++; $display("FAIL itype_retire op=%h state=%0d done=%b ret=%0d required 0 1 %0d", op, state_o, instr_done, retired, exp_ret); end
    end
  endtask

  task automatic test_illegal;
    opcode = 6'h3f; funct = 6'h00; mem_ready = 1'b1; run = 1'b1;
    tick();
    tick();
    checks++; if (state_o !== S_DECODE || illegal !== 1'b0) begin failures++; $display("FAIL ill_decode state=%0d ill=%b required %0d 0", state_o, illegal, S_DECODE); end
    tick();
    checks++; if (state_o !== S_FETCH || illegal !== 1'b1 || instr_done !== 1'b0 || retired !== exp_ret) begin failures++; $display("FAIL ill_pulse state=%0d ill=%b done=%b ret=%0d required %0d 1 0 %0d", state_o, illegal, instr_done, retired, S_FETCH, exp_ret); end
    opcode = 6'h04; run = 1'b0;
    tick();
    checks++; if (state_o !== S_DECODE || illegal !== 1'b0) begin failures++; $display("FAIL ill_pulse_end state=%0d ill=%b required %0d 0", state_o, illegal, S_DECODE); end
    tick();
    tick(); exp_ret++;
    checks++; if (state_o !== S_IDLE || retired !== exp_ret) begin failures++; $display("FAIL ill_resume state=%0d ret=%0d required 0 %0d", state_o, retired, exp_ret); end
  endtask

  task automatic test_reset_mid_and_wrap;
    opcode = 6'h2b; funct = 6'h00; mem_ready = 1'b1; run = 1'b1;
    tick(); run = 1'b0;
    tick();
    tick();
    mem_ready = 1'b0;
    tick();
    tick();
    checks++; if (state_o !== S_MEM_WR || ctrl !== C_MEM_WR || retired !== exp_ret) begin failures++; $display("FAIL mid_pre state=%0d ctrl=%b ret=%0d required %0d %b %0d", state_o, ctrl, retired, S_MEM_WR, C_MEM_WR, exp_ret); end
    rst = 1'b1;
    #1;
    exp_ret = '0;
    checks++; if (state_o !== S_IDLE || ctrl !== C_NONE || retired !== 4'd0 || {instr_done, illegal, mem_timeout} !== 3'b000) begin failures++; $display("FAIL mid_reset state=%0d ctrl=%b ret=%0d pulses=%b required 0", state_o, ctrl, retired, {instr_done, illegal, mem_timeout}); end
    #2;
    rst = 1'b0; opcode = 6'h04; mem_ready = 1'b1; run = 1'b1;
    tick();
    checks++; if (state_o !== S_FETCH || {instr_done, illegal, mem_timeout} !== 3'b000) begin failures++; $display("FAIL mid_restart state=%0d pulses=%b required %0d 000", state_o, {instr_done, illegal, mem_timeout}, S_FETCH); end
    repeat (45) tick();
    checks++; if (state_o !== S_FETCH || retired !== 4'd15 || instr_done !== 1'b1) begin failures++; $display("FAIL wrap_at_15 state=%0d ret=%0d done=%b required %0d 15 1", state_o, retired, instr_done, S_FETCH); end
    repeat (3) tick();
    checks++; if (retired !== 4'd0 || instr_done !== 1'b1) begin failures++; $display("FAIL wrap_to_0 ret=%0d done=%b required 0 1", retired, instr_done); end
    run = 1'b0;
    repeat (3) tick();
    checks++; if (state_o !== S_IDLE || retired !== 4'd1) begin failures++; $display("FAIL wrap_stop state=%0d ret=%0d required 0 1", state_o, retired); end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_sw_timeout();
    test_mem_boundary();
    test_branch_jump();
    test_itype();
    test_illegal();
    test_reset_mid_and_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog sim_time=%0t required finish before 100000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
